// File: rtl/arrow_track_scorer.sv
// rtl/arrow_track_scorer.sv - scrolling arrow track with bottom-row hit judging, score and combo
module arrow_track_scorer #(
  parameter int DEPTH       = 8,
  parameter int BEAT_CYCLES = 25000000,
  parameter int SCORE_W     = 16,
  parameter int COMBO_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           arrow_in,
  input  logic [4:0]           player_dir,
  output logic [5*DEPTH-1:0]   track_out,
  output logic [SCORE_W-1:0]   score,
  output logic [COMBO_W-1:0]   combo,
  output logic                 beat_pulse,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);

  localparam int CNT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

  logic [4:0]         row_q [DEPTH];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               judged_q, judged_d;
  logic [4:0]         pd_meta_q, pd_s_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic               beat_q, hit_q, miss_q;

  logic               beat_tick, match, miss;
  logic [4:0]         bottom;

  always_comb begin
    beat_tick = (cnt_q == CNT_W'(BEAT_CYCLES - 1));
    bottom    = row_q[DEPTH-1];
    match     = (pd_s_q == bottom) && (bottom != 5'd0) && !judged_q;
    // A match on the beat edge is judged against the outgoing row, so it cannot also miss.
    miss      = beat_tick && (bottom != 5'd0) && !judged_q && !match;
    cnt_d     = beat_tick ? '0 : cnt_q + CNT_W'(1);
    judged_d  = beat_tick ? 1'b0 : (judged_q | match);
    score_d   = score_q;
    if (match && (score_q != '1)) score_d = score_q + SCORE_W'(1);
    combo_d   = combo_q;
    if (match) begin
      if (combo_q != '1) combo_d = combo_q + COMBO_W'(1);
    end else if (miss) begin
      combo_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) row_q[r] <= 5'd0;
      cnt_q     <= '0;
      judged_q  <= 1'b0;
      pd_meta_q <= 5'd0;
      pd_s_q    <= 5'd0;
      score_q   <= '0;
      combo_q   <= '0;
      beat_q    <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      judged_q  <= judged_d;
      pd_meta_q <= player_dir;
      pd_s_q    <= pd_meta_q;
      score_q   <= score_d;
      combo_q   <= combo_d;
      beat_q    <= beat_tick;
      hit_q     <= match;
      miss_q    <= miss;
      if (beat_tick) begin
        for (int r = DEPTH - 1; r > 0; r--) row_q[r] <= row_q[r-1];
        row_q[0] <= arrow_in;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_track
    assign track_out[5*g +: 5] = row_q[g];
  end

  assign score      = score_q;
  assign combo      = combo_q;
  assign beat_pulse = beat_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule
